// File: rtl/elc3_seq_alu.sv
// elc3_seq_alu: multi-cycle eLC-3 ALU with start/busy/done handshake and registered NZP/V.
// Define ELC3_ALU_MUL_EN to build the iterative shift-add multiplier for Fn=111 (otherwise Fn=111 is PASSA).
module elc3_seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_fn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_out,
  output logic [2:0]       o_nzp,
  output logic             o_v,
  output logic             o_busy,
  output logic             o_done
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
  state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_out, r_sh, w_sh_nx, w_alu, w_wval, w_sum, w_dif, w_mul_res;
  logic [2:0] r_nzp;
  logic r_v, r_done, r_dir, w_alu_v, w_wr, w_wv, w_go, w_iter_sh, w_fn_mul, w_mul_last, w_mul_v;
  logic [SW-1:0] r_cnt, w_s;
  assign w_s       = i_b[SW-1:0];
  assign w_go      = (r_state == S_IDLE) && i_start;
  assign w_iter_sh = (i_fn == 3'b110) && (w_s != '0);
  assign w_sum     = i_a + i_b;
  assign w_dif     = i_a - i_b;
  assign w_sh_nx   = r_dir ? {r_sh[WIDTH-1], r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
`ifdef ELC3_ALU_MUL_EN
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nx;
  logic [WIDTH-1:0]   r_mplier;
  logic [SW-1:0]      r_mcnt;
  assign w_fn_mul   = i_fn == 3'b111;
  assign w_acc_nx   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = r_mcnt == '0;
  assign w_mul_res  = w_acc_nx[WIDTH-1:0];
  assign w_mul_v    = |w_acc_nx[2*WIDTH-1:WIDTH];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_mcnt   <= '0;
    end else if (w_go && w_fn_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_mcnt   <= SW'(WIDTH - 1);
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_mcnt   <= r_mcnt - SW'(1);
    end
  end
`else
  assign w_fn_mul   = 1'b0;
  assign w_mul_last = 1'b1;
  assign w_mul_res  = '0;
  assign w_mul_v    = 1'b0;
`endif
  // Fn=011, SHIFT by 0 and (without MUL) Fn=111 all fall through to PASSA
  always_comb begin
    w_alu   = i_a;
    w_alu_v = 1'b0;
    case (i_fn)
      3'b000: begin
        w_alu   = w_sum;
        w_alu_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      3'b001: w_alu = i_a & i_b;
      3'b010: w_alu = ~i_a;
      3'b100: begin
        w_alu   = w_dif;
        w_alu_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
      end
      3'b101: w_alu = i_a ^ i_b;
      default: w_alu = i_a;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = !i_start ? S_IDLE : w_fn_mul ? S_MUL : w_iter_sh ? S_SHIFT : S_IDLE;
      S_SHIFT: w_state_nx = (r_cnt == SW'(1)) ? S_IDLE : S_SHIFT;
      default: w_state_nx = w_mul_last ? S_IDLE : r_state;
    endcase
  end
  always_comb begin
    o_busy = r_state != S_IDLE;
    w_wr   = (w_go && !w_fn_mul && !w_iter_sh) || (r_state == S_SHIFT && r_cnt == SW'(1))
           || (r_state == S_MUL && w_mul_last);
    w_wval = (r_state == S_SHIFT) ? w_sh_nx : (r_state == S_MUL) ? w_mul_res : w_alu;
    w_wv   = (r_state == S_SHIFT) ? 1'b0 : (r_state == S_MUL) ? w_mul_v : w_alu_v;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out  <= '0;
      r_nzp  <= 3'b010;
      r_v    <= 1'b0;
      r_done <= 1'b0;
      r_sh   <= '0;
      r_dir  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= w_wr;
      if (w_wr) begin
        r_out <= w_wval;
        r_nzp <= {w_wval[WIDTH-1], w_wval == '0, !w_wval[WIDTH-1] && (w_wval != '0)};
        r_v   <= w_wv;
      end
      if (w_go) begin
        r_sh  <= i_a;
        r_dir <= i_b[WIDTH-1];
        r_cnt <= w_s;
      end else if (r_state == S_SHIFT) begin
        r_sh  <= w_sh_nx;
        r_cnt <= r_cnt - SW'(1);
      end
    end
  end
  assign o_out  = r_out;
  assign o_nzp  = r_nzp;
  assign o_v    = r_v;
  assign o_done = r_done;
endmodule

// File: tb/tb_elc3_seq_alu.sv
// tb_elc3_seq_alu: directed and randomized checks of elc3_seq_alu (WIDTH=16) against an arithmetic reference model.
module tb_elc3_seq_alu;
  logic clk, reset, start, v, busy, done;
  logic [2:0] fn, nzp;
  logic [15:0] a, b, out;
  logic [15:0] m_out;
  logic m_v;
  int errors = 0;
  int checks = 0;
  elc3_seq_alu #(.WIDTH(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_fn(fn), .i_a(a), .i_b(b),
    .o_out(out), .o_nzp(nzp), .o_v(v), .o_busy(busy), .o_done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void model(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] o, output logic ov, output int lat);
    int sx, sy, r, s;
    logic signed [15:0] xs;
    longint unsigned p;
    sx = $signed(x);
    sy = $signed(y);
    xs = x;
    s = int'(y[3:0]);
    o = x;
    ov = 1'b0;
    lat = 1;
    p = 0;
    case (f)
      3'd0: begin r = sx + sy; o = x + y; ov = (r > 32767) || (r < -32768); end
      3'd1: o = x & y;
      3'd2: o = ~x;
      3'd3: o = x;
      3'd4: begin r = sx - sy; o = x - y; ov = (r > 32767) || (r < -32768); end
      3'd5: o = x ^ y;
      3'd6: begin o = y[15] ? 16'(xs >>> s) : 16'(x << s); lat = s + 1; end
      default: begin
`ifdef ELC3_ALU_MUL_EN
        p = {48'b0, x} * {48'b0, y};
        o = p[15:0];
        ov = (p >> 16) != 0;
        lat = 17;
`else
        o = x;
`endif
      end
    endcase
  endfunction
  function automatic logic [2:0] nzp_of(input logic [15:0] o);
    int so;
    so = $signed(o);
    return {so < 0, so == 0, so > 0};
  endfunction
  task automatic do_op(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y,
                       input bit poke, input string nm);
    logic [15:0] eo;
    logic ev;
    int lat;
    model(f, x, y, eo, ev, lat);
    start = 1'b1; fn = f; a = x; b = y;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; fn = 3'($urandom); a = 16'($urandom); b = 16'($urandom); end
      if (poke && c == 2 && lat > 2) begin start = 1'b1; fn = 3'($urandom); a = 16'($urandom); b = 16'($urandom); end
      if (c == 3) start = 1'b0;
      checks++;
      if (busy !== (c < lat)) begin errors++; $display("FAIL %s busy c=%0d got %b exp %b", nm, c, busy, c < lat); end
      checks++;
      if (done !== (c == lat)) begin errors++; $display("FAIL %s done c=%0d got %b exp %b", nm, c, done, c == lat); end
      checks++;
      if (out !== ((c == lat) ? eo : m_out)) begin
        errors++; $display("FAIL %s out c=%0d got %h exp %h", nm, c, out, (c == lat) ? eo : m_out);
      end
      if (c == lat) begin
        checks++;
        if (nzp !== nzp_of(eo)) begin errors++; $display("FAIL %s nzp got %b exp %b", nm, nzp, nzp_of(eo)); end
        checks++;
        if (v !== ev) begin errors++; $display("FAIL %s v got %b exp %b", nm, v, ev); end
      end
    end
    m_out = eo;
    m_v = ev;
  endtask
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out !== m_out) begin
        errors++; $display("FAIL idle got done=%b busy=%b out=%h exp 0 0 %h", done, busy, out, m_out);
      end
    end
  endtask
  task automatic check_reset_state(input string nm);
    checks++;
    if (out !== 16'h0 || nzp !== 3'b010 || v !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got out=%h nzp=%b v=%b busy=%b done=%b exp 0000 010 0 0 0", nm, out, nzp, v, busy, done);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset_released");
    m_out = 16'h0;
    m_v = 1'b0;
  endtask
  task automatic test_add_sub();
    do_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    do_op(3'd4, 16'd5, 16'd5, 1'b0, "sub_b2b");
    do_op(3'd4, 16'h8000, 16'h0001, 1'b0, "sub_ovf");
    do_op(3'd1, 16'hF0F0, 16'h3C3C, 1'b0, "and");
    do_op(3'd2, 16'h00FF, 16'h1234, 1'b0, "not");
    do_op(3'd3, 16'h4321, 16'hFFFF, 1'b0, "passa");
    do_op(3'd5, 16'hAAAA, 16'h0FF0, 1'b0, "xor");
    idle(2);
  endtask
  task automatic test_shift();
    do_op(3'd6, 16'h8001, 16'h8004, 1'b1, "shift_sra4");
    idle(1);
    do_op(3'd6, 16'h0003, 16'h0000, 1'b0, "shift_0");
    do_op(3'd6, 16'h0003, 16'h000F, 1'b1, "shift_sll15");
    do_op(3'd6, 16'h7000, 16'h8003, 1'b0, "shift_sra_pos");
    idle(2);
  endtask
  task automatic test_mul();
`ifdef ELC3_ALU_MUL_EN
    do_op(3'd7, 16'd300, 16'd300, 1'b1, "mul_300");
    do_op(3'd7, 16'd3, 16'hFFFE, 1'b0, "mul_neg");
    do_op(3'd7, 16'd7, 16'd9, 1'b0, "mul_small");
`else
    do_op(3'd7, 16'h1234, 16'h5678, 1'b0, "fn7_passa");
`endif
    idle(2);
  endtask
  task automatic test_reset_mid();
    start = 1'b1;
`ifdef ELC3_ALU_MUL_EN
    fn = 3'd7; a = 16'd300; b = 16'd300;
`else
    fn = 3'd6; a = 16'd1; b = 16'h000F;
`endif
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || out !== m_out) begin
        errors++; $display("FAIL mid_op c=%0d got busy=%b done=%b out=%h exp 1 0 %h", c, busy, done, out, m_out);
      end
      if (c == 8) reset = 1'b1;
    end
    @(negedge clk);
    check_reset_state("reset_mid");
    reset = 1'b0;
    m_out = 16'h0;
    m_v = 1'b0;
    do_op(3'd0, 16'd1, 16'd1, 1'b0, "add_after_reset");
    idle(1);
  endtask
  task automatic test_back_to_back();
    logic [2:0] f;
    logic [15:0] x, y;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) y[3:0] = 4'h0;
      do_op(f, x, y, 1'($urandom_range(0, 1)), "random");
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; fn = 3'd0; a = 16'h0; b = 16'h0;
    m_out = 16'h0; m_v = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_shift();
    test_mul();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
